// File: rtl/sensor_timing_gen_if.sv
// ============================================================================
// Module  : sensor_timing_gen_if
// Brief   : FSM next-state input plus timing/strobe/address outputs of the
//           sensor timing datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sensor_timing_gen_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       nstate;
  logic [CNT_W-1:0] ctrl_vsync_cnt;
  logic [CNT_W-1:0] ctrl_hsync_cnt;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             ctrl_done;
  logic             VSYNC;
  logic             HSYNC;
  logic             data_en;
  logic [CNT_W-1:0] pix_addr_even;
  logic [CNT_W-1:0] pix_addr_odd;
  logic [15:0]      frame_cnt;
  logic             timing_err;

  modport master (
    output nstate,
    input  ctrl_vsync_cnt, ctrl_hsync_cnt, col, row, ctrl_done,
    input  VSYNC, HSYNC, data_en, pix_addr_even, pix_addr_odd,
    input  frame_cnt, timing_err
  );

  modport slave (
    input  nstate,
    output ctrl_vsync_cnt, ctrl_hsync_cnt, col, row, ctrl_done,
    output VSYNC, HSYNC, data_en, pix_addr_even, pix_addr_odd,
    output frame_cnt, timing_err
  );
endinterface

`default_nettype wire

// File: rtl/sensor_timing_gen.sv
// ============================================================================
// Module  : sensor_timing_gen
// Brief   : Frame timing counters, sync strobes and 2-pixel/clock addresses
//           driven by the frame FSM next state. Optional protocol checker
//           enabled by defining SENSOR_TIMING_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_timing_gen #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240,
  parameter int CNT_W  = 32
) (
  input  wire logic HCLK,
  input  wire logic HRESETn,
  sensor_timing_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VSYNC = 2'b01,
    ST_HSYNC = 2'b10,
    ST_DATA  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_LAST_ROW = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] c_LAST_COL = CNT_W'(WIDTH - 2);

  state_t           r_st;
  state_t           w_ns;
  logic             r_vs, r_hs, r_de;
  logic [CNT_W-1:0] r_vcnt, r_hcnt, r_col, r_row, r_addr, r_odd;
  logic [CNT_W-1:0] w_vcnt_nxt, w_hcnt_nxt, w_col_nxt, w_row_nxt, w_addr_nxt;
  logic [15:0]      r_fc;
  logic             w_frame_clr;
  logic             w_done;

  assign w_ns = state_t'(bus.nstate);

  always_comb begin
    w_vcnt_nxt  = '0;
    w_hcnt_nxt  = '0;
    w_col_nxt   = '0;
    w_row_nxt   = r_row;
    w_addr_nxt  = r_addr;
    w_frame_clr = (w_ns == ST_IDLE) || (w_ns == ST_VSYNC);
    if (w_ns == ST_VSYNC) w_vcnt_nxt = r_vcnt + c_ONE;
    if (w_ns == ST_HSYNC) w_hcnt_nxt = r_hcnt + c_ONE;
    if ((w_ns == ST_DATA) && (r_st == ST_DATA)) w_col_nxt = r_col + c_TWO;
    // The address advances per beat, so it tracks row*WIDTH+col without a multiply.
    if (w_frame_clr) begin
      w_row_nxt  = '0;
      w_addr_nxt = '0;
    end else if (r_st == ST_DATA) begin
      w_addr_nxt = r_addr + c_TWO;
      if (w_ns == ST_HSYNC) w_row_nxt = r_row + c_ONE;
    end
  end

  assign w_done = (r_st == ST_DATA) && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_st   <= ST_IDLE;
      r_vs   <= 1'b0;
      r_hs   <= 1'b0;
      r_de   <= 1'b0;
      r_vcnt <= '0;
      r_hcnt <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_odd  <= '0;
      r_fc   <= '0;
    end else begin
      r_st   <= w_ns;
      r_vs   <= (w_ns == ST_VSYNC);
      r_hs   <= (w_ns == ST_HSYNC);
      r_de   <= (w_ns == ST_DATA);
      r_vcnt <= w_vcnt_nxt;
      r_hcnt <= w_hcnt_nxt;
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_addr <= w_addr_nxt;
      r_odd  <= w_addr_nxt + c_ONE;
      r_fc   <= r_fc + {15'd0, w_done};
    end
  end

`ifdef SENSOR_TIMING_CHECK_EN
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    case (r_st)
      ST_IDLE:  w_bad = (w_ns == ST_HSYNC) || (w_ns == ST_DATA);
      ST_VSYNC: w_bad = (w_ns == ST_IDLE)  || (w_ns == ST_DATA);
      ST_HSYNC: w_bad = (w_ns == ST_IDLE)  || (w_ns == ST_VSYNC);
      ST_DATA:  w_bad = (w_ns == ST_VSYNC);
      default:  w_bad = 1'b0;
    endcase
    // Flag the overrunning beat itself rather than one cycle later.
    if ((w_ns == ST_DATA) && (w_col_nxt > c_LAST_COL)) w_bad = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_err <= 1'b0;
    else          r_err <= r_err | w_bad;
  end

  assign bus.timing_err = r_err;
`else
  assign bus.timing_err = 1'b0;
`endif

  assign bus.ctrl_vsync_cnt = r_vcnt;
  assign bus.ctrl_hsync_cnt = r_hcnt;
  assign bus.col            = r_col;
  assign bus.row            = r_row;
  assign bus.ctrl_done      = w_done;
  assign bus.VSYNC          = r_vs;
  assign bus.HSYNC          = r_hs;
  assign bus.data_en        = r_de;
  assign bus.pix_addr_even  = r_addr;
  assign bus.pix_addr_odd   = r_odd;
  assign bus.frame_cnt      = r_fc;

endmodule

`default_nettype wire

// File: tb/tb_sensor_timing_gen.sv
// ============================================================================
// Module  : tb_sensor_timing_gen
// Brief   : Self-checking bench for sensor_timing_gen (WIDTH=8, HEIGHT=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_timing_gen;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int CNT_W  = 32;
  localparam logic [1:0] I = 2'b00, V = 2'b01, H = 2'b10, D = 2'b11;
`ifdef SENSOR_TIMING_CHECK_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif

  typedef struct {
    logic [1:0] ns;
    bit         vs, hs, de;
    int         vc, hc, col, row, addr;
    bit         done;
    int         fc;
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  sensor_timing_gen_if #(.CNT_W(CNT_W)) bus ();

  sensor_timing_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_fc = 0;
  bit   m_pend = 1'b0;
  bit   m_err = 1'b0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ns, input bit vs, input bit hs, input bit de,
                              input int vc, input int hc, input int col, input int row,
                              input int addr, input bit done, input int fc);
    vec_t e;
    e.ns = ns; e.vs = vs; e.hs = hs; e.de = de; e.vc = vc; e.hc = hc;
    e.col = col; e.row = row; e.addr = addr; e.done = done; e.fc = fc;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_vsync"}, {31'd0, bus.VSYNC}, 0);
    chk({tag, "_hsync"}, {31'd0, bus.HSYNC}, 0);
    chk({tag, "_de"},    {31'd0, bus.data_en}, 0);
    chk({tag, "_vcnt"},  bus.ctrl_vsync_cnt, 0);
    chk({tag, "_hcnt"},  bus.ctrl_hsync_cnt, 0);
    chk({tag, "_col"},   bus.col, 0);
    chk({tag, "_row"},   bus.row, 0);
    chk({tag, "_even"},  bus.pix_addr_even, 0);
    chk({tag, "_odd"},   bus.pix_addr_odd, 0);
    chk({tag, "_done"},  {31'd0, bus.ctrl_done}, 0);
    chk({tag, "_fc"},    {16'd0, bus.frame_cnt}, 0);
    chk({tag, "_err"},   {31'd0, bus.timing_err}, 0);
  endtask

  // Drive one next-state value, then compare everything one step after the edge.
  task automatic step(input vec_t e);
    bus.nstate = e.ns;
    @(posedge HCLK);
    #1;
    cyc++;
    chk("vsync", {31'd0, bus.VSYNC}, {31'd0, e.vs});
    chk("hsync", {31'd0, bus.HSYNC}, {31'd0, e.hs});
    chk("data_en", {31'd0, bus.data_en}, {31'd0, e.de});
    chk("vsync_cnt", bus.ctrl_vsync_cnt, e.vc);
    chk("hsync_cnt", bus.ctrl_hsync_cnt, e.hc);
    chk("col", bus.col, e.col);
    chk("row", bus.row, e.row);
    chk("addr_even", bus.pix_addr_even, e.addr);
    if (e.de) chk("addr_odd", bus.pix_addr_odd, e.addr + 1);
    chk("done", {31'd0, bus.ctrl_done}, {31'd0, e.done});
    chk("frame_cnt", {16'd0, bus.frame_cnt}, e.fc);
    chk("timing_err", {31'd0, bus.timing_err}, {31'd0, m_err});
  endtask

  // Reference model: outputs derived from the phase position within the frame.
  task automatic mstep(input logic [1:0] ns, input bit vs, input bit hs, input bit de,
                       input int vc, input int hc, input int col, input int row,
                       input int addr, input bit done);
    if (m_pend) m_fc = (m_fc + 1) % 65536;
    step(mk(ns, vs, hs, de, vc, hc, col, row, addr, done, m_fc));
    m_pend = done;
  endtask

  task automatic m_idle(input int n);
    for (int i = 0; i < n; i++) mstep(I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic m_vsync(input int n, input int start);
    for (int i = 0; i < n; i++) mstep(V, 1, 0, 0, start + i + 1, 0, 0, 0, 0, 0);
  endtask

  task automatic m_line(input int r, input int hs, input int beats, input int base);
    for (int i = 0; i < hs; i++) mstep(H, 0, 1, 0, 0, i + 1, 0, r, base, 0);
    for (int k = 0; k < beats; k++)
      mstep(D, 0, 0, 1, 0, 0, 2 * k, r, base + 2 * k,
            (r == HEIGHT - 1) && (2 * k == WIDTH - 2));
  endtask

  task automatic m_frame(input int idle, input int vs, input int hs, input int lines,
                         input int beats);
    m_idle(idle);
    m_vsync(vs, 0);
    for (int r = 0; r < lines; r++) m_line(r, hs, beats, 2 * beats * r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Golden first frame: VSYNC x3, then 4 lines of HSYNC x2 + 4 beats, one IDLE.
    tbl.push_back(mk(V,1,0,0,1,0,0,0,0,0,0));  tbl.push_back(mk(V,1,0,0,2,0,0,0,0,0,0));
    tbl.push_back(mk(V,1,0,0,3,0,0,0,0,0,0));
    tbl.push_back(mk(H,0,1,0,0,1,0,0,0,0,0));  tbl.push_back(mk(H,0,1,0,0,2,0,0,0,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,0,0,0,0,0));  tbl.push_back(mk(D,0,0,1,0,0,2,0,2,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,4,0,4,0,0));  tbl.push_back(mk(D,0,0,1,0,0,6,0,6,0,0));
    tbl.push_back(mk(H,0,1,0,0,1,0,1,8,0,0));  tbl.push_back(mk(H,0,1,0,0,2,0,1,8,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,0,1,8,0,0));  tbl.push_back(mk(D,0,0,1,0,0,2,1,10,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,4,1,12,0,0)); tbl.push_back(mk(D,0,0,1,0,0,6,1,14,0,0));
    tbl.push_back(mk(H,0,1,0,0,1,0,2,16,0,0)); tbl.push_back(mk(H,0,1,0,0,2,0,2,16,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,0,2,16,0,0)); tbl.push_back(mk(D,0,0,1,0,0,2,2,18,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,4,2,20,0,0)); tbl.push_back(mk(D,0,0,1,0,0,6,2,22,0,0));
    tbl.push_back(mk(H,0,1,0,0,1,0,3,24,0,0)); tbl.push_back(mk(H,0,1,0,0,2,0,3,24,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,0,3,24,0,0)); tbl.push_back(mk(D,0,0,1,0,0,2,3,26,0,0));
    tbl.push_back(mk(D,0,0,1,0,0,4,3,28,0,0)); tbl.push_back(mk(D,0,0,1,0,0,6,3,30,1,0));
    tbl.push_back(mk(I,0,0,0,0,0,0,0,0,0,1));  tbl.push_back(mk(V,1,0,0,1,0,0,0,0,0,1));

    bus.nstate = I;
    repeat (3) @(posedge HCLK);
    #1;
    chk_zero("reset");
    HRESETn = 1'b1;

    foreach (tbl[i]) step(tbl[i]);
    m_fc = 1;
    m_pend = 1'b0;

    // Abort mid-line at row 2, col 4, then restart a clean frame.
    m_vsync(2, 1);
    m_line(0, 2, 4, 0);
    m_line(1, 2, 4, 8);
    m_line(2, 2, 3, 16);
    chk("pre_abort_col", bus.col, 4);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_zero("abort");
    m_fc = 0;
    m_pend = 1'b0;
    bus.nstate = I;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    m_frame(0, 3, 2, 4, 4);
    m_idle(1);

    // Randomized frames with varied phase lengths, line counts and line lengths.
    for (int f = 0; f < 25; f++) begin
      int beats;
      beats = ($urandom_range(0, 1) == 0) ? WIDTH / 2 : int'($urandom_range(1, WIDTH / 2));
      m_frame(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 3)), int'($urandom_range(1, 5)), beats);
    end
    m_idle(1);

    // Frame counter wrap from 0xFFFF.
    force dut.r_fc = 16'hFFFF;
    @(negedge HCLK);
    release dut.r_fc;
    m_fc = 16'hFFFF;
    m_pend = 1'b0;
    m_idle(1);
    m_frame(0, 3, 2, 4, 4);
    m_idle(1);
    chk("wrap_fc", {16'd0, bus.frame_cnt}, 0);

    // Illegal DATA->VSYNC is sticky until reset.
    m_vsync(1, 0);
    m_line(0, 1, 2, 0);
    m_err = c_CHK;
    mstep(V, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    m_idle(3);
    HRESETn = 1'b0;
    #1;
    m_err = 1'b0;
    m_fc = 0;
    m_pend = 1'b0;
    chk_zero("err_clear");
    bus.nstate = I;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Line overrun: a fifth beat reaches col=WIDTH.
    m_vsync(1, 0);
    m_line(0, 1, 4, 0);
    m_err = c_CHK;
    mstep(D, 0, 0, 1, 0, 0, 8, 0, 8, 0);
    m_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
